// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundle between the functional-unit result ports / CDB snoopers and the
// CDB arbiter.
//   req_valid [N_REQ]        requester i holds a completed result
//   req_tag   [N_REQ*TAG_W]  tag of requester i, slice [i*TAG_W +: TAG_W]
//   req_data  [N_REQ*DATA_W] value of requester i, slice [i*DATA_W +: DATA_W]
//   flush                    pipeline flush, blocks grants
//   req_ready [N_REQ]        one-hot grant back to the requesters
//   cdb_valid/cdb_tag/cdb_data  registered one-cycle broadcast
//   err_tag0                 sticky: a tag-0 result was granted
// master: requester/snooper side.  slave: the arbiter.
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    flush;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic                    err_tag0;

    modport master (
        output req_valid, req_tag, req_data, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, err_tag0
    );

    modport slave (
        input  req_valid, req_tag, req_data, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data, err_tag0
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the Common Data Bus. Picks at most one completed
// functional-unit result per cycle and drives it onto a registered one-cycle
// broadcast that reservation stations and the register status table snoop.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    cdb_arbiter_if.slave (requests, flush, grants, broadcast, err_tag0)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  r_ptr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic              r_err_tag0;

    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic [N_REQ-1:0]  w_grant;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_data;
    int                w_idx;

    // Scan from r_ptr upward with wrap; the first valid requester wins.
    // Only req_valid, r_ptr, flush and rst_n feed the grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_grant = '0;
        w_idx   = 0;
        if (rst_n && !bus.flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
                if (!w_found && bus.req_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = PTR_W'(w_idx);
                end
            end
        end
        if (w_found) w_grant[w_win] = 1'b1;
    end

    assign w_tag  = bus.req_tag[int'(w_win)*TAG_W +: TAG_W];
    assign w_data = bus.req_data[int'(w_win)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_err_tag0  <= 1'b0;
        end else begin
            r_cdb_valid <= 1'b0;
            if (w_found) begin
                // Winner drops to lowest priority; explicit wrap keeps
                // non-power-of-two N_REQ inside 0..N_REQ-1.
                if (int'(w_win) == N_REQ - 1) r_ptr <= '0;
                else                          r_ptr <= w_win + 1'b1;
                // Tag 0 means "no producer": consume it but never broadcast.
                if (w_tag != '0) begin
                    r_cdb_valid <= 1'b1;
                    r_cdb_tag   <= w_tag;
                    r_cdb_data  <= w_data;
                end else begin
                    r_err_tag0  <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
    assign bus.err_tag0  = r_err_tag0;
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: the winner is the valid requester closest to the
    // pointer going upward modulo N.
    int          m_ptr;
    logic        m_valid;
    logic [3:0]  m_tag;
    logic [31:0] m_data;
    logic        m_err;

    function automatic int model_winner(input logic [3:0] v, input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - ptr + N) % N;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    logic [3:0]  a_ready;
    logic        a_cv;
    logic [3:0]  a_tag;
    logic [31:0] a_data;
    logic        a_err;

    // One clock cycle: drive inputs, check grant combinationally, then check
    // the registered outputs after the edge against the model.
    task automatic run_cycle(input logic rn, input logic fl, input logic [3:0] v,
                             input logic [15:0] tags, input logic [127:0] data);
        int w;
        logic [3:0] e_ready;
        rst_n         = rn;
        bus.flush     = fl;
        bus.req_valid = v;
        bus.req_tag   = tags;
        bus.req_data  = data;
        #1;
        w = (rn && !fl) ? model_winner(v, m_ptr) : -1;
        e_ready = '0;
        if (w >= 0) e_ready[w] = 1'b1;
        a_ready = bus.req_ready;
        chk("model_ready", {28'h0, a_ready}, {28'h0, e_ready});
        if (!rn) begin
            m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_err = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (tags[w*4 +: 4] != 4'd0) begin
                    m_valid = 1'b1;
                    m_tag   = tags[w*4 +: 4];
                    m_data  = data[w*32 +: 32];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        a_cv   = bus.cdb_valid;
        a_tag  = bus.cdb_tag;
        a_data = bus.cdb_data;
        a_err  = bus.err_tag0;
        chk("model_cdb_valid", {31'h0, a_cv}, {31'h0, m_valid});
        chk("model_cdb_tag", {28'h0, a_tag}, {28'h0, m_tag});
        chk("model_cdb_data", a_data, m_data);
        chk("model_err_tag0", {31'h0, a_err}, {31'h0, m_err});
    endtask

    typedef struct {
        logic        rn;
        logic        fl;
        logic [3:0]  v;
        logic [15:0] tags;
        logic [127:0] data;
        logic [3:0]  e_ready;
        logic        e_cv;
        logic [3:0]  e_tag;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic fl, input logic [3:0] v,
                                input logic [15:0] tags, input logic [127:0] data,
                                input logic [3:0] er, input logic ecv,
                                input logic [3:0] et, input logic [31:0] ed,
                                input logic ee);
        vec_t r;
        r.rn = rn; r.fl = fl; r.v = v; r.tags = tags; r.data = data;
        r.e_ready = er; r.e_cv = ecv; r.e_tag = et; r.e_data = ed; r.e_err = ee;
        return r;
    endfunction

    logic        hv [N];
    logic [3:0]  ht [N];
    logic [31:0] hd [N];

    initial begin
        logic [127:0] dD;
        logic [127:0] dS;
        logic [127:0] dA;
        logic [15:0]  tg;
        logic [127:0] dt;
        logic [3:0]   vv;
        logic         rr, ff;

        dD = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        dS = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
        dA = {32'h0, 32'h0, 32'hA1, 32'hA0};

        // rn fl v tags data | ready cv tag data err
        vecs.push_back(mk(0, 0, 4'b0000, 16'h0, '0, 4'b0000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 16'h0, '0, 4'b0000, 0, 4'h0, 32'h0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 4'b0000, 16'h0, '0, 4'b0000, 0, 4'h0, 32'h0, 0));
        // single request, requester 2, tag 5
        vecs.push_back(mk(1, 0, 4'b0100, 16'h0500, dS, 4'b0100, 1, 4'h5, 32'h1234_5678, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 16'h0500, dS, 4'b0000, 0, 4'h5, 32'h1234_5678, 0));
        // rotation with wrap from ptr 3
        vecs.push_back(mk(1, 0, 4'b0011, 16'h0021, dA, 4'b0001, 1, 4'h1, 32'hA0, 0));
        vecs.push_back(mk(1, 0, 4'b0010, 16'h0021, dA, 4'b0010, 1, 4'h2, 32'hA1, 0));
        // reset during an active broadcast, then full contention
        vecs.push_back(mk(0, 0, 4'b1111, 16'h4321, dD, 4'b0000, 0, 4'h0, 32'h0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 4'b1111, 16'h4321, dD, 4'(1 << (i % 4)), 1,
                              4'((i % 4) + 1), 32'hD0 + 32'(i % 4), 0));
        // flush: grant T, flush T+1/T+2, resume T+3
        vecs.push_back(mk(1, 0, 4'b1111, 16'h4321, dD, 4'b0001, 1, 4'h1, 32'hD0, 0));
        vecs.push_back(mk(1, 1, 4'b1111, 16'h4321, dD, 4'b0000, 0, 4'h1, 32'hD0, 0));
        vecs.push_back(mk(1, 1, 4'b1111, 16'h4321, dD, 4'b0000, 0, 4'h1, 32'hD0, 0));
        vecs.push_back(mk(1, 0, 4'b1111, 16'h4321, dD, 4'b0010, 1, 4'h2, 32'hD1, 0));
        // tag 0 on requester 1
        vecs.push_back(mk(1, 0, 4'b0010, 16'h4301, dD, 4'b0010, 0, 4'h2, 32'hD1, 1));
        vecs.push_back(mk(1, 0, 4'b0000, 16'h4301, dD, 4'b0000, 0, 4'h2, 32'hD1, 1));
        vecs.push_back(mk(1, 0, 4'b1000, 16'h4321, dD, 4'b1000, 1, 4'h4, 32'hD3, 1));
        // reset clears the broadcast and the sticky error
        vecs.push_back(mk(0, 0, 4'b0000, 16'h4321, dD, 4'b0000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 16'h4321, dD, 4'b0000, 0, 4'h0, 32'h0, 0));

        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = '0;
        bus.req_tag = '0;
        bus.req_data = '0;
        m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_err = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            run_cycle(vecs[k].rn, vecs[k].fl, vecs[k].v, vecs[k].tags, vecs[k].data);
            chk($sformatf("vec%0d_ready", k), {28'h0, a_ready}, {28'h0, vecs[k].e_ready});
            chk($sformatf("vec%0d_cdb_valid", k), {31'h0, a_cv}, {31'h0, vecs[k].e_cv});
            chk($sformatf("vec%0d_cdb_tag", k), {28'h0, a_tag}, {28'h0, vecs[k].e_tag});
            chk($sformatf("vec%0d_cdb_data", k), a_data, vecs[k].e_data);
            chk($sformatf("vec%0d_err_tag0", k), {31'h0, a_err}, {31'h0, vecs[k].e_err});
        end

        // Randomized traffic with requesters holding until granted.
        for (int i = 0; i < N; i++) begin
            hv[i] = 1'b0; ht[i] = '0; hd[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hv[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        hv[i] = 1'b1;
                        ht[i] = 4'($urandom_range(0, 15));
                        hd[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    hv[i] = 1'b0;
                end
            end
            rr = ($urandom_range(0, 63) != 0);
            ff = ($urandom_range(0, 7) == 0);
            vv = '0;
            tg = '0;
            dt = '0;
            for (int i = 0; i < N; i++) begin
                vv[i] = hv[i];
                tg[i*4 +: 4] = ht[i];
                dt[i*32 +: 32] = hd[i];
            end
            run_cycle(rr, ff, vv, tg, dt);
            for (int i = 0; i < N; i++)
                if (a_ready[i]) hv[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
